// File: rtl/alu_sequencer.sv
// alu_sequencer: issues requests to the datapath ALU and gathers the
// result and flags into a 2-entry response buffer.
module alu_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned OP_WIDTH    = 3,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_WIDTH-1:0]  req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic [OP_WIDTH-1:0]  alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_overflow,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_trap,
  output logic                 rsp_illegal,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 busy
);

  localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3'b000);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3'b001);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(3'b010);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(3'b110);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(3'b111);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    logic                 zero;
    logic                 trap;
    logic                 illegal;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 ready_en;
  logic [1:0]           count;
  rsp_t                 head_q, tail_q, push_data;
  logic                 op_legal, accept, push, pop, load_alu, cnt_last;

  // Handshake decode; ready_en keeps req_ready low until the first clock after reset.
  always_comb begin
    op_legal  = req_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    req_ready = ready_en && (state == S_IDLE) && (count < 2'd2);
    accept    = req_valid && req_ready;
    rsp_valid = (count != 2'd0);
    pop       = rsp_valid && rsp_ready;
    cnt_last  = (cnt == CNT_W'(1));
    busy      = (state == S_WAIT);
  end

  // Next-state logic plus the response push for illegal accepts and ALU completion.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    load_alu  = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_legal) begin
            load_alu  = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            push              = 1'b1;
            push_data.zero    = 1'b1;
            push_data.illegal = 1'b1;
            push_data.tag     = req_tag;
          end
        end
      end
      S_WAIT: begin
        if (cnt_last) begin
          push             = 1'b1;
          push_data.result = alu_result;
          push_data.zero   = alu_zero;
          push_data.trap   = alu_overflow && ((alu_op == OP_ADD) || (alu_op == OP_SUB));
          push_data.tag    = tag_q;
          state_nxt        = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Request gating becomes active on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // ALU operand registers, held tag and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      tag_q  <= '0;
      cnt    <= '0;
    end else if (load_alu) begin
      alu_op <= req_op;
      alu_a  <= req_a;
      alu_b  <= req_b;
      tag_q  <= req_tag;
      cnt    <= CNT_W'(ALU_LATENCY);
    end else if (state == S_WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Two-entry shift FIFO: head_q drives rsp_* directly, so it simply keeps
  // its contents when the buffer drains to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head_q <= tail_q;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_result  = head_q.result;
  assign rsp_zero    = head_q.zero;
  assign rsp_trap    = head_q.trap;
  assign rsp_illegal = head_q.illegal;
  assign rsp_tag     = head_q.tag;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance at ALU_LATENCY=1, one at ALU_LATENCY=2.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic        rsp_ready;
  logic        v1, v2;

  logic        r1_ready, o1_valid, o1_zero, o1_trap, o1_illegal, b1_busy, a1_ovf, a1_zero;
  logic [2:0]  a1_op;
  logic [31:0] a1_a, a1_b, a1_res, o1_result;
  logic [3:0]  o1_tag;

  logic        r2_ready, o2_valid, o2_zero, o2_trap, o2_illegal, b2_busy, a2_ovf, a2_zero;
  logic [2:0]  a2_op;
  logic [31:0] a2_a, a2_b, a2_res, o2_result;
  logic [3:0]  o2_tag;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] r;
    logic        z;
    logic        t;
    logic        il;
  } vec_t;

  vec_t q1[$];
  vec_t q2[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_pop = -1;
  bit   stream_on = 1'b0;

  // Behavioural ALU; AND/OR deliberately assert overflow so the trap gating is exercised.
  function automatic logic [33:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, d;
    logic        ov;
    d  = a - b;
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    case (op)
      3'b000: begin r = a & b; ov = 1'b1; end
      3'b001: begin r = a | b; ov = 1'b1; end
      3'b010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: r = d;
      3'b111: r = {31'b0, ($signed(a) < $signed(b))};
      default: begin r = 32'hDEAD_BEEF; ov = 1'b1; end
    endcase
    return {ov, (r == 32'd0), r};
  endfunction

  assign {a1_ovf, a1_zero, a1_res} = alu_model(a1_op, a1_a, a1_b);
  assign {a2_ovf, a2_zero, a2_res} = alu_model(a2_op, a2_a, a2_b);

  alu_sequencer #(.WIDTH(32), .OP_WIDTH(3), .TAG_WIDTH(4), .ALU_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(a1_op), .alu_a(a1_a), .alu_b(a1_b),
    .alu_result(a1_res), .alu_overflow(a1_ovf), .alu_zero(a1_zero),
    .rsp_valid(o1_valid), .rsp_ready(rsp_ready), .rsp_result(o1_result),
    .rsp_zero(o1_zero), .rsp_trap(o1_trap), .rsp_illegal(o1_illegal),
    .rsp_tag(o1_tag), .busy(b1_busy)
  );

  alu_sequencer #(.WIDTH(32), .OP_WIDTH(3), .TAG_WIDTH(4), .ALU_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(r2_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(a2_op), .alu_a(a2_a), .alu_b(a2_b),
    .alu_result(a2_res), .alu_overflow(a2_ovf), .alu_zero(a2_zero),
    .rsp_valid(o2_valid), .rsp_ready(rsp_ready), .rsp_result(o2_result),
    .rsp_zero(o2_zero), .rsp_trap(o2_trap), .rsp_illegal(o2_illegal),
    .rsp_tag(o2_tag), .busy(b2_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tag, input logic [31:0] r,
                              input logic z, input logic t, input logic il);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.r = r; v.z = z; v.t = t; v.il = il;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the latency-1 instance.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n && o1_valid && rsp_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp1_unexpected: got tag %0d, required no response", o1_tag);
      end else begin
        e = q1.pop_front();
        chk($sformatf("rsp1_tag%0d {result,zero,trap,illegal,tag}", e.tag),
            {25'd0, o1_result, o1_zero, o1_trap, o1_illegal, o1_tag},
            {25'd0, e.r, e.z, e.t, e.il, e.tag});
      end
    end
  end

  // Scoreboard for the latency-2 instance, plus spacing check while streaming.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n && o2_valid && rsp_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp2_unexpected: got tag %0d, required no response", o2_tag);
      end else begin
        e = q2.pop_front();
        chk($sformatf("rsp2_tag%0d {result,zero,trap,illegal,tag}", e.tag),
            {25'd0, o2_result, o2_zero, o2_trap, o2_illegal, o2_tag},
            {25'd0, e.r, e.z, e.t, e.il, e.tag});
      end
      if (stream_on) begin
        if (last_pop >= 0) chk("stream_interval", 64'(cyc - last_pop), 64'd3);
        last_pop = cyc;
      end
    end
  end

  // Drive one request; expectation is queued at the accepting edge. Returns #1 after that edge.
  task automatic send(input bit s2, input vec_t v, input bit hold);
    bit ok = 1'b0;
    req_op = v.op; req_a = v.a; req_b = v.b; req_tag = v.tag;
    if (s2) v2 = 1'b1; else v1 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (s2 ? r2_ready : r1_ready) begin
        ok = 1'b1;
        if (s2) q2.push_back(v); else q1.push_back(v);
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout tag%0d: got no accept in 60 cycles, required accept", v.tag);
    end
    @(posedge clk); #1;
    if (!hold) begin v1 = 1'b0; v2 = 1'b0; end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q1.size() == 0 && q2.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0", q1.size(), q2.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    v1 = 1'b0; v2 = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;

    tbl[0]  = mk(3'b010, 32'h7FFF_FFFF, 32'h1,         4'd3,  32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(3'b110, 32'd5,         32'd5,         4'd4,  32'h0,         1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(3'b111, 32'hFFFF_FFFF, 32'h1,         4'd5,  32'h1,         1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 4'd6,  32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 4'd7,  32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(3'b011, 32'h1234_5678, 32'h1,         4'd9,  32'h0,         1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(3'b110, 32'h8000_0000, 32'h1,         4'd10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(3'b111, 32'h8000_0000, 32'h1,         4'd11, 32'h1,         1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(3'b010, 32'hFFFF_FFFF, 32'h1,         4'd12, 32'h0,         1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(3'b100, 32'h5,         32'h6,         4'd13, 32'h0,         1'b1, 1'b0, 1'b1);
    tbl[10] = mk(3'b000, 32'h0,         32'hFFFF_FFFF, 4'd14, 32'h0,         1'b1, 1'b0, 1'b0);
    tbl[11] = mk(3'b101, 32'h7,         32'h8,         4'd15, 32'h0,         1'b1, 1'b0, 1'b1);

    // Reset values and req_ready rising one cycle after release.
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {58'd0, r1_ready, o1_valid, b1_busy, r2_ready, o2_valid, b2_busy}, 64'd0);
    chk("reset_alu_op_a", {29'd0, a1_op, a1_a}, 64'd0);
    chk("reset_alu_b", {32'd0, a1_b}, 64'd0);
    chk("reset_rsp", {25'd0, o1_result, o1_zero, o1_trap, o1_illegal, o1_tag}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("ready_release_cycle0", {63'd0, r1_ready}, 64'd0);
    @(negedge clk); chk("ready_release_cycle1", {63'd0, r1_ready}, 64'd1);
    @(posedge clk); #1;

    // Table vectors through the latency-1 instance.
    for (int i = 0; i < 12; i++) send(1'b0, tbl[i], 1'b0);
    wait_drain();

    // Illegal op: no ALU update, no WAIT.
    send(1'b0, mk(3'b110, 32'd9, 32'd4, 4'd1, 32'd5, 1'b0, 1'b0, 1'b0), 1'b0);
    wait_drain();
    send(1'b0, mk(3'b011, 32'hAAAA_AAAA, 32'h5, 4'd9, 32'h0, 1'b1, 1'b0, 1'b1), 1'b0);
    chk("illegal_rsp_valid_next", {63'd0, o1_valid}, 64'd1);
    @(negedge clk);
    chk("illegal_busy", {63'd0, b1_busy}, 64'd0);
    chk("illegal_alu_op_kept", {61'd0, a1_op}, 64'd6);
    wait_drain();
    c0 = cyc;
    send(1'b0, mk(3'b100, 32'h1, 32'h2, 4'd10, 32'h0, 1'b1, 1'b0, 1'b1), 1'b1);
    send(1'b0, mk(3'b101, 32'h3, 32'h4, 4'd11, 32'h0, 1'b1, 1'b0, 1'b1), 1'b0);
    chk("illegal_throughput_cycles", 64'(cyc - c0), 64'd2);
    wait_drain();

    // Backpressure: two buffered, third held until a pop.
    rsp_ready = 1'b0;
    send(1'b0, mk(3'b010, 32'd1, 32'd1, 4'd0, 32'd2, 1'b0, 1'b0, 1'b0), 1'b0);
    send(1'b0, mk(3'b001, 32'd3, 32'd4, 4'd1, 32'd7, 1'b0, 1'b0, 1'b0), 1'b0);
    fork
      send(1'b0, mk(3'b000, 32'd6, 32'd3, 4'd2, 32'd2, 1'b0, 1'b0, 1'b0), 1'b0);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("bp_full_ready_%0d", k), {63'd0, r1_ready}, 64'd0);
          chk($sformatf("bp_head_stable_%0d", k), {27'd0, o1_valid, o1_result, o1_tag}, {27'd0, 1'b1, 32'd2, 4'd0});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset while the ALU op is outstanding.
    send(1'b0, mk(3'b010, 32'd1, 32'd2, 4'd5, 32'd3, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("busy_in_wait", {63'd0, b1_busy}, 64'd1);
    rst_n = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("midreset_state", {58'd0, b1_busy, o1_valid, r1_ready, a1_op}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("midreset_ready_cycle0", {63'd0, r1_ready}, 64'd0);
    @(negedge clk); chk("midreset_ready_cycle1", {63'd0, r1_ready}, 64'd1);
    @(posedge clk); #1;

    // Streaming on the latency-2 instance.
    stream_on = 1'b1;
    send(1'b1, mk(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 4'd0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0), 1'b1);
    send(1'b1, mk(3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 4'd1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0), 1'b1);
    send(1'b1, mk(3'b010, 32'd2, 32'd3, 4'd2, 32'd5, 1'b0, 1'b0, 1'b0), 1'b1);
    send(1'b1, mk(3'b110, 32'd3, 32'd5, 4'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), 1'b0);
    wait_drain();
    stream_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
